// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller shared by instruction fetch and the
// load/store unit. One transaction is in flight at a time; each access walks
// the byte RAM one address per cycle, assembling reads little-endian and
// sign/zero-extending sub-word loads.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   flush                    aborts an in-progress fetch/load (stores complete)
//   if_req/if_addr           fetch request (held until if_done) and address
//   if_done/if_data          one-cycle completion pulse and fetched word
//   ls_req/ls_store/ls_size  load/store request, direction, size (0=B,1=H,2/3=W)
//   ls_unsigned              zero-extend sub-word loads
//   ls_addr/ls_wdata         access address and store data (low bytes used)
//   ls_done/ls_rdata         one-cycle completion pulse and extended load data
//   mem_din/mem_dout         RAM read byte (one cycle after address) / write byte
//   mem_a/mem_wr             RAM byte address and write strobe
//
// Build option: define MEM_CTRL_IF_PRIO_EN to let a fetch win when both
// requests arrive together in IDLE; by default the data request wins.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_store,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] addr, addr_nxt;
  logic [2:0]  len, len_nxt;
  logic        uns, uns_nxt;
  logic        fetch, fetch_nxt;
  logic [31:0] wdata, wdata_nxt;
  logic [31:0] asm_w, asm_nxt;

  logic        if_done_nxt, ls_done_nxt, mem_wr_nxt;
  logic [31:0] if_data_nxt, ls_rdata_nxt, mem_a_nxt;
  logic [7:0]  mem_dout_nxt;

  logic        take_if, take_ls;
  logic [2:0]  cnt_inc;
  logic [1:0]  lane_rd, lane_wr;
  logic [31:0] next_a;
  logic [31:0] asm_cap;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Fetches and word loads arrive with n=4 and pass through untouched.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] n,
                                         input logic zero_ext);
    case (n)
      3'd1:    return zero_ext ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      3'd2:    return zero_ext ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

`ifdef MEM_CTRL_IF_PRIO_EN
  assign take_if = if_req;
`else
  assign take_if = if_req & ~ls_req;
`endif
  assign take_ls = ls_req & ~take_if;

  // cnt counts cycles spent in READ/WRITE from 0; in READ the byte arriving
  // on mem_din belongs to the address issued one cycle earlier (lane cnt-1).
  assign cnt_inc = cnt + 3'd1;
  assign lane_rd = cnt[1:0] - 2'd1;
  assign lane_wr = cnt[1:0] + 2'd1;
  assign next_a  = addr + 32'(cnt_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr     <= '0;
      len      <= '0;
      uns      <= 1'b0;
      fetch    <= 1'b0;
      wdata    <= '0;
      asm_w    <= '0;
      if_done  <= 1'b0;
      if_data  <= '0;
      ls_done  <= 1'b0;
      ls_rdata <= '0;
      mem_dout <= '0;
      mem_a    <= '0;
      mem_wr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      addr     <= addr_nxt;
      len      <= len_nxt;
      uns      <= uns_nxt;
      fetch    <= fetch_nxt;
      wdata    <= wdata_nxt;
      asm_w    <= asm_nxt;
      if_done  <= if_done_nxt;
      if_data  <= if_data_nxt;
      ls_done  <= ls_done_nxt;
      ls_rdata <= ls_rdata_nxt;
      mem_dout <= mem_dout_nxt;
      mem_a    <= mem_a_nxt;
      mem_wr   <= mem_wr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    addr_nxt     = addr;
    len_nxt      = len;
    uns_nxt      = uns;
    fetch_nxt    = fetch;
    wdata_nxt    = wdata;
    asm_nxt      = asm_w;
    if_done_nxt  = 1'b0;
    ls_done_nxt  = 1'b0;
    if_data_nxt  = if_data;
    ls_rdata_nxt = ls_rdata;
    mem_a_nxt    = '0;
    mem_wr_nxt   = 1'b0;
    mem_dout_nxt = '0;

    asm_cap = asm_w;
    asm_cap[{lane_rd, 3'b000} +: 8] = mem_din;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        asm_nxt = '0;
        if (take_if) begin
          state_nxt = READ;
          fetch_nxt = 1'b1;
          len_nxt   = 3'd4;
          uns_nxt   = 1'b0;
          addr_nxt  = if_addr;
          mem_a_nxt = if_addr;
        end else if (take_ls) begin
          fetch_nxt = 1'b0;
          len_nxt   = byte_count(ls_size);
          uns_nxt   = ls_unsigned;
          addr_nxt  = ls_addr;
          wdata_nxt = ls_wdata;
          mem_a_nxt = ls_addr;
          if (ls_store) begin
            state_nxt    = WRITE;
            mem_wr_nxt   = 1'b1;
            mem_dout_nxt = ls_wdata[7:0];
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt != 3'd0) asm_nxt = asm_cap;
          if (cnt_inc < len) mem_a_nxt = next_a;
          if (cnt == len) begin
            state_nxt = DONE;
            if (fetch) begin
              if_done_nxt = 1'b1;
              if_data_nxt = asm_cap;
            end else begin
              ls_done_nxt  = 1'b1;
              ls_rdata_nxt = extend(asm_cap, len, uns);
            end
          end
        end
      end
      WRITE: begin
        // Stores are already committed, so flush is deliberately not looked at.
        cnt_nxt = cnt_inc;
        if (cnt_inc < len) begin
          mem_a_nxt    = next_a;
          mem_wr_nxt   = 1'b1;
          mem_dout_nxt = wdata[{lane_wr, 3'b000} +: 8];
        end else begin
          state_nxt   = DONE;
          ls_done_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl. A byte RAM model
// answers the DUT one cycle after each address; a separate reference memory
// plus per-transaction arithmetic predicts addresses, write bytes, done timing
// and the extended results cycle by cycle.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_store;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] last_if = '0;
  logic [31:0] last_ls = '0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_store(ls_store), .ls_size(ls_size),
    .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Synchronous-read byte RAM.
  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  task automatic idle_check();
    @(negedge clk);
    check_val("idle_mem_a", mem_a, 32'h0);
    check_val("idle_mem_wr", {31'd0, mem_wr}, 32'h0);
    check_val("idle_mem_dout", {24'd0, mem_dout}, 32'h0);
    check_val("idle_if_done", {31'd0, if_done}, 32'h0);
    check_val("idle_ls_done", {31'd0, ls_done}, 32'h0);
    check_val("hold_if_data", if_data, last_if);
    check_val("hold_ls_rdata", ls_rdata, last_ls);
  endtask

  // kind: 0=fetch, 1=load, 2=store. flush_at: cycle (1-based after E0) in
  // which flush is held high, 0 for none. pend: also raise the other
  // requester's line (its fields preset by the caller) in the same cycle.
  task automatic txn(input int kind, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int flush_at, input bit pend);
    int          n, last;
    bit          abort;
    logic [31:0] exp_data, exp_a;
    logic [7:0]  exp_dout;
    logic        exp_wr, exp_ifd, exp_lsd;
    n = (kind == 0) ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    exp_data = '0;
    for (int i = 0; i < n; i++) exp_data[8*i +: 8] = ref_rd(addr + 32'(i));
    if (kind == 1 && n == 1) exp_data = uns ? {24'd0, exp_data[7:0]}  : {{24{exp_data[7]}}, exp_data[7:0]};
    if (kind == 1 && n == 2) exp_data = uns ? {16'd0, exp_data[15:0]} : {{16{exp_data[15]}}, exp_data[15:0]};
    abort = (kind != 2) && flush_at >= 1 && flush_at <= n + 1;
    last  = (kind == 2) ? n + 1 : n + 2;

    @(negedge clk);
    if (kind == 0) begin
      if_addr = addr;
      if_req  = 1'b1;
      if (pend) ls_req = 1'b1;
    end else begin
      ls_addr     = addr;
      ls_store    = (kind == 2);
      ls_size     = size;
      ls_unsigned = uns;
      ls_wdata    = wd;
      ls_req      = 1'b1;
      if (pend) if_req = 1'b1;
    end

    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1;
      flush = (k == flush_at);
      if (abort && k == flush_at) begin
        if (kind == 0) if_req = 1'b0;
        else ls_req = 1'b0;
      end
      @(negedge clk);
      exp_a = '0; exp_wr = 1'b0; exp_dout = '0; exp_ifd = 1'b0; exp_lsd = 1'b0;
      if (kind == 2) begin
        if (k <= n) begin
          exp_a    = addr + 32'(k - 1);
          exp_wr   = 1'b1;
          exp_dout = wd[8*(k-1) +: 8];
        end
        exp_lsd = (k == n + 1);
      end else begin
        if (k <= n && !(abort && k > flush_at)) exp_a = addr + 32'(k - 1);
        if (!abort && k == n + 2) begin
          if (kind == 0) exp_ifd = 1'b1;
          else exp_lsd = 1'b1;
        end
      end
      check_val("mem_a", mem_a, exp_a);
      check_val("mem_wr", {31'd0, mem_wr}, {31'd0, exp_wr});
      check_val("mem_dout", {24'd0, mem_dout}, {24'd0, exp_dout});
      check_val("if_done", {31'd0, if_done}, {31'd0, exp_ifd});
      check_val("ls_done", {31'd0, ls_done}, {31'd0, exp_lsd});
      if (exp_ifd) begin
        last_if = exp_data;
        check_val("if_data", if_data, exp_data);
      end
      if (exp_lsd && kind == 1) begin
        last_ls = exp_data;
        check_val("ls_rdata", ls_rdata, exp_data);
      end
    end
    flush = 1'b0;
    if (kind == 0) if_req = 1'b0;
    else ls_req = 1'b0;

    if (kind == 2) begin
      for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wd[8*i +: 8];
      for (int i = 0; i < 4; i++)
        check_val("ram_bytes", {24'd0, ram_rd(addr + 32'(i))}, {24'd0, ref_rd(addr + 32'(i))});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_store = 1'b0; ls_size = '0; ls_unsigned = 1'b0;
    ls_addr = '0; ls_wdata = '0;

    repeat (3) @(negedge clk);
    check_val("rst_mem_a", mem_a, 32'h0);
    check_val("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
    check_val("rst_if_data", if_data, 32'h0);
    check_val("rst_ls_rdata", ls_rdata, 32'h0);
    check_val("rst_dones", {30'd0, if_done, ls_done}, 32'h0);
    rst = 1'b0;

    // Fetch of 0x00000513 at 0x1000.
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    txn(0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, 1'b0);
    check_val("fetch_513", if_data, 32'h00000513);
    idle_check();

    // LB / LBU of 0x80.
    preload(32'h20, 8'h80);
    txn(1, 2'd0, 1'b0, 32'h20, 32'h0, 0, 1'b0);
    check_val("lb_sext", ls_rdata, 32'hFFFFFF80);
    txn(1, 2'd0, 1'b1, 32'h20, 32'h0, 0, 1'b0);
    check_val("lbu_zext", ls_rdata, 32'h00000080);
    idle_check();

    // SH of 0xDEADBEEF at 0x40; 0x42 must stay untouched.
    preload(32'h42, 8'h5A);
    txn(2, 2'd1, 1'b0, 32'h40, 32'hDEADBEEF, 0, 1'b0);
    check_val("sh_keep_42", {24'd0, ram_rd(32'h42)}, 32'h5A);

    // Simultaneous requests.
`ifdef MEM_CTRL_IF_PRIO_EN
    ls_addr = 32'h1000; ls_size = 2'd2; ls_store = 1'b0; ls_unsigned = 1'b0;
    txn(0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, 1'b1);
    txn(1, 2'd2, 1'b0, 32'h1000, 32'h0, 0, 1'b0);
`else
    if_addr = 32'h1000;
    txn(1, 2'd2, 1'b0, 32'h1000, 32'h0, 0, 1'b1);
    txn(0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, 1'b0);
`endif
    idle_check();

    // Flush in cycle 3 of a fetch aborts; flush in cycle 2 of SW is ignored.
    txn(0, 2'd2, 1'b0, 32'h1000, 32'h0, 3, 1'b0);
    idle_check();
    txn(2, 2'd2, 1'b0, 32'h60, 32'hA1B2C3D4, 2, 1'b0);
    idle_check();

    // Word load wrapping the address space.
    preload(32'hFFFFFFFE, 8'h11); preload(32'hFFFFFFFF, 8'h22);
    preload(32'h0, 8'h33);        preload(32'h1, 8'h44);
    txn(1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 0, 1'b0);
    check_val("lw_wrap", ls_rdata, 32'h44332211);

    // Reset in cycle 2 of a load.
    @(negedge clk);
    ls_addr = 32'h1000; ls_size = 2'd2; ls_store = 1'b0; ls_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; ls_req = 1'b0;
    #1;
    check_val("arst_mem_a", mem_a, 32'h0);
    check_val("arst_outs", {29'd0, mem_wr, if_done, ls_done}, 32'h0);
    check_val("arst_data", if_data | ls_rdata | {24'd0, mem_dout}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    last_if = '0;
    last_ls = '0;
    repeat (6) idle_check();

    // Randomized traffic over a preloaded window.
    for (int a = 32'h100; a < 32'h180; a++) preload(32'(a), 8'($urandom));
    for (int t = 0; t < 60; t++) begin
      int          kind, fa;
      logic [1:0]  sz;
      logic        un;
      logic [31:0] ad;
      kind = int'($urandom_range(0, 2));
      sz   = 2'($urandom_range(0, 3));
      un   = 1'($urandom_range(0, 1));
      ad   = 32'h100 + $urandom_range(0, 32'h7B);
      fa   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
      txn(kind, sz, un, ad, $urandom, fa, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
